prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Writer side of the instruction-fetch interface. Receives a program as a byte stream, assembles 16-bit instructions, and writes them into a 16-entry instruction RAM.
- Serves the CPU fetch port with the same 1-cycle registered-read timing the CPU already expects from its instruction store.
- Holds the CPU in reset until a checksum-verified program is loaded, then releases it.

Parameters:
- DEPTH, 16, number of instruction words in the RAM.
- ADDR_W, 4, RAM index width; equals log2(DEPTH).
- INST_W, 16, instruction width: opcode[15:12], dest[11:8], arg1[7:4], arg2[3:0].

Ports:
- clk  in  1  single system clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data holds a byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- fetch_addr  in  8  CPU program counter (r[0]).
- fetch_inst  out  16  registered instruction for fetch_addr.
- cpu_run  out  1  1 = CPU may execute; 0 = CPU held in reset.
- load_done  out  1  1-cycle pulse when the program is accepted.
- err  out  1  sticky load-error flag.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears all state.
  - State goes to IDLE.
  - Outputs: in_ready=1 (IDLE value), fetch_inst=0 (NOP), cpu_run=0, load_done=0, err=0.
  - Counters and running checksum are cleared. RAM contents are don't-care.
  - Reset asserted mid-load aborts the load; the next byte after reset is treated as a header.
- Byte transfer: a byte transfers only when in_valid && in_ready at a clk edge.
  - in_ready=1 in IDLE, HI, LO and CSUM; 0 in RUN and ERR.
- IDLE: the transferred byte is N, the instruction count.
  - N=0 or N>DEPTH: go to ERR.
  - Otherwise: latch N, set word counter wc=0, set csum=N, go to HI.
- HI: latch the byte as inst[15:8], csum^=byte, go to LO.
- LO: write {hi,byte} to RAM[wc] on the same edge, csum^=byte, wc++.
  - If wc+1==N go to CSUM, else go to HI.
- CSUM: compare the byte against csum.
  - Equal: go to RUN; cpu_run=1 from the next cycle; load_done pulses for exactly that one cycle.
  - Not equal: go to ERR.
- RUN: terminal; the only exit is reset. in_valid is ignored.
- ERR: terminal; err=1, cpu_run=0; the only exit is reset.
- Fetch: fetch_inst is registered with 1-cycle latency.
  - In RUN: fetch_inst <= RAM[fetch_addr[3:0]] if fetch_addr<N; otherwise 0 (NOP).
  - Outside RUN: fetch_inst <= 0.
  - fetch_addr wrap (8-bit, 255->0) needs no special handling; out-of-range addresses simply read NOP.
- Unwritten RAM entries are never presented to the CPU because of the fetch_addr<N gate.
- Idle cycles between bytes are allowed in any state with no timeout.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants NOP..XOR (4'd0..4'd15);
  - INST_W and DEPTH;
  - loader state enum {IDLE, HI, LO, CSUM, RUN, ERR}.
- One sub-module, inst_ram:
  - DEPTH x INST_W;
  - one synchronous write port and one synchronous read port;
  - no reset.
- prog_loader contains the FSM, checksum logic and fetch gating, and instantiates inst_ram.

Test Plan:
1. Reset, then stream 01,31,05,35; run fetch_addr 0,1 → in_ready drops after 35; load_done pulses once; cpu_run=1; fetch_inst=0x3105 one cycle after addr 0; 0x0000 for addr 1.
2. Stream 02,31,05,81,11,csum=02^31^05^81^11=0xA6; fetch addrs 0,1,2,200 → 0x3105, 0x8111, 0x0000, 0x0000 with 1-cycle latency.
3. Stream 01,31,05,34 (bad checksum) → err=1, cpu_run=0, in_ready=0; fetch_inst stays 0; held until reset.
4. Header 00, and separately header 11 (17 > DEPTH) → each goes to ERR on the header byte; no RAM write.
5. Send 02,31,05, gaps of 5 idle cycles with in_valid=0, then pull rst_n low for 1 cycle, then send 01,31,05,35 → the clean load succeeds; the aborted partial load has no effect; fetch addr 0 → 0x3105.
6. Send 16 words (N=0x10) with the matching checksum; fetch addrs 0..15 → every word reads back in order; in_valid pulses after RUN are ignored (in_ready=0, no state change).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction geometry, opcode constants and the
// program-loader state encoding.
package cpu_pkg;

    localparam int INST_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_MOV = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_INC = 4'd5;
    localparam logic [3:0] OP_DEC = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_LD  = 4'd9;
    localparam logic [3:0] OP_ST  = 4'd10;
    localparam logic [3:0] OP_JMP = 4'd11;
    localparam logic [3:0] OP_JZ  = 4'd12;
    localparam logic [3:0] OP_AND = 4'd13;
    localparam logic [3:0] OP_OR  = 4'd14;
    localparam logic [3:0] OP_XOR = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } ld_state_t;

    // A header is usable only if it names between 1 and DEPTH instructions.
    function automatic logic hdr_valid(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(DEPTH));
    endfunction

endpackage

// File: rtl/inst_ram.sv
// Instruction store: one synchronous write port, one registered read port.
// No reset; contents are undefined until the loader writes them.
module inst_ram #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles 16-bit words into inst_ram, verifies
// an XOR checksum, then releases the CPU and serves its fetch port.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | waiting for header byte N (instruction count)
//   HI      | waiting for instruction high byte
//   LO      | waiting for low byte; writes the word to RAM
//   CSUM    | waiting for checksum byte
//   RUN     | program accepted, CPU running (exit only by reset)
//   ERR     | bad header or checksum, CPU held (exit only by reset)
module prog_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [7:0]        fetch_addr,
    output logic [INST_W-1:0] fetch_inst,
    output logic              cpu_run,
    output logic              load_done,
    output logic              err
);

    ld_state_t   state_q, state_d;
    logic [4:0]  n_q, n_d;
    logic [4:0]  wc_q, wc_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  csum_q, csum_d;
    logic        done_q, done_d;
    logic        gate_q, gate_d;
    logic        xfer;
    logic        ram_we;
    logic [INST_W-1:0] ram_rdata;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_HI) ||
                      (state_q == ST_LO)   || (state_q == ST_CSUM);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wc_d    = wc_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        done_d  = 1'b0;
        ram_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (hdr_valid(in_data)) begin
                        n_d     = in_data[4:0];
                        wc_d    = 5'd0;
                        csum_d  = in_data;
                        state_d = ST_HI;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    ram_we  = 1'b1;
                    csum_d  = csum_q ^ in_data;
                    wc_d    = wc_q + 5'd1;
                    state_d = (wc_q + 5'd1 == n_q) ? ST_CSUM : ST_HI;
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (in_data == csum_q) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    // Gate is registered alongside the RAM read so both land on the same edge.
    assign gate_d = (state_q == ST_RUN) && (fetch_addr < {3'b000, n_q});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= 5'd0;
            wc_q    <= 5'd0;
            hi_q    <= 8'd0;
            csum_q  <= 8'd0;
            done_q  <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wc_q    <= wc_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            gate_q  <= gate_d;
        end
    end

    inst_ram #(
        .DEPTH  (DEPTH),
        .INST_W (INST_W),
        .ADDR_W (ADDR_W)
    ) u_inst_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wc_q[ADDR_W-1:0]),
        .wdata ({hi_q, in_data}),
        .raddr (fetch_addr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    assign fetch_inst = gate_q ? ram_rdata : '0;
    assign cpu_run    = (state_q == ST_RUN);
    assign load_done  = done_q;
    assign err        = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed loads plus randomized programs
// compared against a byte-stream reference model.
module tb_prog_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  fetch_addr;
    logic [15:0] fetch_inst;
    logic        cpu_run;
    logic        load_done;
    logic        err;

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fetch_addr (fetch_addr),
        .fetch_inst (fetch_inst),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [7:0]  byte_q[$];
    logic [15:0] words[16];
    logic [15:0] exp_mem[16];
    int          exp_n;
    bit          exp_run;
    bit          exp_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: interpret a whole byte stream and decide the final outcome.
    function automatic void model_load();
        int  n;
        logic [7:0] x;
        exp_run = 0;
        exp_err = 0;
        exp_n   = 0;
        if (byte_q.size() == 0) return;
        n = int'(byte_q[0]);
        if (n == 0 || n > 16) begin
            exp_err = 1;
            return;
        end
        if (byte_q.size() < 2 * n + 2) return;
        x = 8'h00;
        for (int i = 0; i < 2 * n + 1; i++) x = x ^ byte_q[i];
        if (byte_q[2 * n + 1] != x) begin
            exp_err = 1;
            return;
        end
        exp_run = 1;
        exp_n   = n;
        for (int i = 0; i < n; i++) exp_mem[i] = {byte_q[1 + 2 * i], byte_q[2 + 2 * i]};
    endfunction

    task automatic build_prog(input int n, input bit bad);
        logic [7:0] x;
        byte_q.delete();
        x = 8'(n);
        byte_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            byte_q.push_back(words[i][15:8]);
            byte_q.push_back(words[i][7:0]);
            x = x ^ words[i][15:8] ^ words[i][7:0];
        end
        if (bad) x = x ^ 8'($urandom_range(1, 255));
        byte_q.push_back(x);
    endtask

    task automatic reset_dut();
        in_valid = 0;
        rst_n    = 0;
        tick();
        rst_n    = 1;
    endtask

    task automatic stream();
        for (int i = 0; i < byte_q.size(); i++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                in_valid = 0;
                in_data  = 8'($urandom);
                tick();
            end
            in_valid = 1;
            in_data  = byte_q[i];
            tick();
            in_valid = 0;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_in_ready"},  in_ready,  !(exp_run || exp_err));
        check({tag, "_cpu_run"},   cpu_run,   exp_run);
        check({tag, "_err"},       err,       exp_err);
        check({tag, "_load_done"}, load_done, exp_run);
        tick();
        check({tag, "_done_pulse"}, load_done, 1'b0);
    endtask

    task automatic load_and_check(input string tag);
        reset_dut();
        model_load();
        stream();
        check_status(tag);
    endtask

    task automatic fetch_check(input string tag, input int a);
        logic [15:0] e;
        fetch_addr = 8'(a);
        tick();
        e = (exp_run && a < exp_n) ? exp_mem[a] : 16'h0000;
        check(tag, fetch_inst, e);
    endtask

    initial begin
        clk        = 0;
        rst_n      = 0;
        in_valid   = 0;
        in_data    = 0;
        fetch_addr = 0;

        reset_dut();
        check("rst_in_ready",   in_ready,   1'b1);
        check("rst_fetch_inst", fetch_inst, 16'h0000);
        check("rst_cpu_run",    cpu_run,    1'b0);
        check("rst_load_done",  load_done,  1'b0);
        check("rst_err",        err,        1'b0);

        byte_q = '{8'h01, 8'h31, 8'h05, 8'h35};
        load_and_check("tp1");
        fetch_check("tp1_f0", 0);
        check("tp1_f0_lit", fetch_inst, 16'h3105);
        fetch_check("tp1_f1", 1);

        byte_q = '{8'h02, 8'h31, 8'h05, 8'h81, 8'h11, 8'hA6};
        load_and_check("tp2");
        check("tp2_run_lit", cpu_run, 1'b1);
        fetch_check("tp2_f0", 0);
        fetch_check("tp2_f1", 1);
        check("tp2_f1_lit", fetch_inst, 16'h8111);
        fetch_check("tp2_f2", 2);
        fetch_check("tp2_f200", 200);

        byte_q = '{8'h01, 8'h31, 8'h05, 8'h34};
        load_and_check("tp3");
        check("tp3_err_lit", err, 1'b1);
        fetch_check("tp3_f0", 0);
        for (int i = 0; i < 4; i++) tick();
        check("tp3_err_held", err, 1'b1);

        byte_q = '{8'h00};
        load_and_check("tp4_hdr0");
        byte_q = '{8'h11};
        load_and_check("tp4_hdr17");
        fetch_check("tp4_f0", 0);

        reset_dut();
        byte_q = '{8'h02, 8'h31, 8'h05};
        stream();
        for (int i = 0; i < 5; i++) tick();
        check("tp5_partial_ready", in_ready, 1'b1);
        check("tp5_partial_run",   cpu_run,  1'b0);
        byte_q = '{8'h01, 8'h31, 8'h05, 8'h35};
        load_and_check("tp5");
        fetch_check("tp5_f0", 0);
        check("tp5_f0_lit", fetch_inst, 16'h3105);

        for (int i = 0; i < 16; i++) words[i] = 16'hA000 + 16'(i) * 16'h0101;
        build_prog(16, 0);
        load_and_check("tp6");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 0;
        check("tp6_post_ready", in_ready,  1'b0);
        check("tp6_post_run",   cpu_run,   1'b1);
        check("tp6_post_done",  load_done, 1'b0);
        for (int a = 0; a <= 16; a++) fetch_check("tp6_fetch", a);
        fetch_check("tp6_f255", 255);

        for (int it = 0; it < 8; it++) begin
            int kind = int'($urandom_range(0, 5));
            int n    = int'($urandom_range(1, 16));
            for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
            if (kind == 0) begin
                byte_q.delete();
                byte_q.push_back(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(17, 255)));
            end else begin
                build_prog(n, kind == 1);
            end
            load_and_check("rnd");
            for (int k = 0; k < 6; k++) begin
                int a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, n + 1))
                                                    : int'($urandom_range(0, 255));
                fetch_check("rnd_fetch", a);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
